mult_sequencer: RTL and testbench
=================================

# mult_sequencer

Sequencer and two-port arbiter for the shared `binary_multiplier` datapath. It accepts operand pairs from two requesters and grants them round-robin. It drives the multiplier's load and start strobes in the required order, waits for completion, and returns the 2N-bit product with a per-requester done pulse. A watchdog aborts a stuck multiplication and flags an error.

## Interface
Parameters:
- `N`, 4, operand width; must match the multiplier's `N`.
- `TIMEOUT`, 64, maximum cycles spent in WAIT_BUSY plus WAIT_DONE before abort; must be greater than the multiplier's worst-case latency.

Ports (one clock; reset is asynchronous and active-high):
- `CLK`  in  1  clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `REQ0`, `REQ1`  in  1 each  level request; hold high until the matching ACK.
- `A0`, `B0`, `A1`, `B1`  in  N each  operands; stable while REQ is high.
- `ACK0`, `ACK1`  out  1 each  one-cycle pulse: operands captured.
- `DONE0`, `DONE1`  out  1 each  one-cycle pulse: RESULT/ERR valid for this requester.
- `RESULT`  out  2N  product register; holds until the next RESP.
- `ERR`  out  1  high with DONE if the operation timed out.
- `BUSY`  out  1  high whenever state is not IDLE.
- `M_LOADB`, `M_LOADQ`, `M_G`  out  1 each  to multiplier `LOADB`/`LOADQ`/`G`.
- `M_IN`  out  N  to multiplier `MULT_IN`.
- `M_OUT`  in  2N  from multiplier `MULT_OUT`.
- `M_FINISH`  in  1  from multiplier `MULT_FINISH`.

## Operation
- FSM states: IDLE, GRANT, LOAD_B, LOAD_Q, START, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE → GRANT when any REQ is high.
- Arbitration:
  - If only one requester is asserting, it wins.
  - If both assert, the requester not served last wins.
  - The `last` pointer updates in GRANT and resets to 1, so requester 0 wins the first tie.
- GRANT:
  - ACK of the winner is high.
  - Winner's A and B are latched into internal regs, and the winner ID is latched.
  - Next state is LOAD_B.
- LOAD_B: `M_LOADB`=1, `M_IN`=latched A. Next state is LOAD_Q.
- LOAD_Q: `M_LOADQ`=1, `M_IN`=latched B. Next state is START.
- START: `M_G`=1, `M_IN`=0. Next state is WAIT_BUSY, and the watchdog counter is cleared.
- WAIT_BUSY waits for `M_FINISH`=0, which tolerates a level-high idle FINISH. Next state is WAIT_DONE.
- WAIT_DONE waits for `M_FINISH`=1. On that edge, `M_OUT` → RESULT, ERR←0, next state is RESP.
- Watchdog:
  - The counter increments every cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT−1 without completion: RESULT←0, ERR←1, next state is RESP.
- RESP: DONE of the latched ID is high, then the FSM returns to IDLE.
- All strobes are low outside their named state. `M_IN` is 0 outside LOAD_B and LOAD_Q.
- Arithmetic is unsigned. RESULT is exactly `M_OUT`; there is no truncation and no re-computation.

## Timing
- Reset values: state=IDLE, `last`=1, counter=0. RESULT=0, ERR=0, BUSY=0; all ACK, DONE and M_* outputs are 0.
- Outputs are Moore-decoded from registered state. RESULT and ERR are registered.
- Cycle sequence with REQ sampled high in IDLE at edge k:
  - GRANT/ACK in cycle k+1.
  - LOAD_B in cycle k+2.
  - LOAD_Q in cycle k+3.
  - START in cycle k+4.
  - WAIT_BUSY from cycle k+5.
- Minimum latency from the sampling edge to DONE is 7 cycles, plus the multiplier latency.
- REQ changes outside IDLE are ignored. A losing requester keeps REQ high and is granted on the next pass through IDLE.
- A requester that drops REQ before ACK is not served, provided the drop happens before the IDLE sampling edge.
- Requests are not queued, so back-to-back service costs one IDLE cycle between RESP and GRANT.
- RESET asserted mid-operation:
  - Immediately forces the IDLE and reset values above.
  - The in-flight result is discarded and no DONE is issued.
  - The multiplier shares `RESET`.
  - A requester still holding REQ is re-granted after reset is released.
- If `M_FINISH` is already low in the WAIT_BUSY entry cycle, WAIT_BUSY lasts exactly 1 cycle.

## Test plan
- Single request, REQ0 with A0=3, B0=2 → ACK0 pulse, then LOADB/LOADQ/G pulses on consecutive cycles, then DONE0 with RESULT=6 and ERR=0; DONE1 never asserts.
- Simultaneous requests, REQ0 with 5×7 and REQ1 with 15×15 asserted in the same cycle after reset → requester 0 is served first (RESULT=35), then requester 1 (RESULT=225). Repeating both requests → requester 0 is served first again (`last`=1).
- Round-robin fairness: REQ0 and REQ1 held high continuously → DONE0 and DONE1 alternate over 4 operations with correct products.
- Zero and maximum operands: 0×9 → RESULT=0; 15×15 → RESULT=225 (8'hE1) with no overflow.
- Timeout: replace the multiplier with a stub that holds `M_FINISH`=0 after start → DONE pulse after TIMEOUT cycles in the wait states, with ERR=1 and RESULT=0; the next normal request succeeds.
- Reset mid-operation: assert RESET during WAIT_DONE → all outputs go to 0 within the same cycle (async) and no DONE follows; release with REQ1 still high → requester 1 is re-granted and returns the correct product.

Source files
------------

// File: rtl/mult_sequencer.sv
// Sequencer and round-robin two-port arbiter in front of a shared binary_multiplier.
// Drives load/start strobes in order, waits for completion, and aborts on a watchdog timeout.
module mult_sequencer #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           REQ0,
  input  logic           REQ1,
  input  logic [N-1:0]   A0,
  input  logic [N-1:0]   B0,
  input  logic [N-1:0]   A1,
  input  logic [N-1:0]   B1,
  output logic           ACK0,
  output logic           ACK1,
  output logic           DONE0,
  output logic           DONE1,
  output logic [2*N-1:0] RESULT,
  output logic           ERR,
  output logic           BUSY,
  output logic           M_LOADB,
  output logic           M_LOADQ,
  output logic           M_G,
  output logic [N-1:0]   M_IN,
  input  logic [2*N-1:0] M_OUT,
  input  logic           M_FINISH
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_LOAD_B, S_LOAD_Q, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last;
  logic            r_id;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_result;
  logic            r_err;
  logic            w_winner;
  logic            w_any_req;
  logic            w_timeout;

  assign w_any_req = REQ0 | REQ1;
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // On a tie the requester that was not served last wins.
  always_comb begin
    if (REQ0 && REQ1) w_winner = ~r_last;
    else              w_winner = REQ1;
  end

  // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_any_req) w_next = S_GRANT;
      S_GRANT:     w_next = S_LOAD_B;
      S_LOAD_B:    w_next = S_LOAD_Q;
      S_LOAD_Q:    w_next = S_START;
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_timeout)      w_next = S_RESP;
        else if (!M_FINISH) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (M_FINISH || w_timeout) w_next = S_RESP;
      S_RESP:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any_req) r_id <= w_winner;
        S_GRANT: begin
          r_last <= r_id;
          r_a    <= r_id ? A1 : A0;
          r_b    <= r_id ? B1 : B0;
        end
        S_START: r_cnt <= '0;
        S_WAIT_BUSY, S_WAIT_DONE: begin
          r_cnt <= r_cnt + CW'(1);
          // Completion wins over a timeout landing on the same cycle.
          if (r_state == S_WAIT_DONE && M_FINISH) begin
            r_result <= M_OUT;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ACK0    = (r_state == S_GRANT) && !r_id;
  assign ACK1    = (r_state == S_GRANT) &&  r_id;
  assign DONE0   = (r_state == S_RESP)  && !r_id;
  assign DONE1   = (r_state == S_RESP)  &&  r_id;
  assign BUSY    = (r_state != S_IDLE);
  assign M_LOADB = (r_state == S_LOAD_B);
  assign M_LOADQ = (r_state == S_LOAD_Q);
  assign M_G     = (r_state == S_START);
  assign RESULT  = r_result;
  assign ERR     = r_err;

  always_comb begin
    M_IN = '0;
    if (r_state == S_LOAD_B)      M_IN = r_a;
    else if (r_state == S_LOAD_Q) M_IN = r_b;
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer with a behavioural multiplier stub and
// an arbitration/product reference model.
module tb_mult_sequencer;

  localparam int N  = 4;
  localparam int W  = 2 * N;
  localparam int TO = 20;

  logic          CLK, RESET;
  logic          REQ0, REQ1;
  logic [N-1:0]  A0, B0, A1, B1;
  logic          ACK0, ACK1, DONE0, DONE1, ERR, BUSY;
  logic [W-1:0]  RESULT;
  logic          M_LOADB, M_LOADQ, M_G;
  logic [N-1:0]  M_IN;
  logic [W-1:0]  s_out;
  logic          s_fin;

  int n_tests = 0;
  int n_fail  = 0;

  mult_sequencer #(.N(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .ACK0(ACK0), .ACK1(ACK1), .DONE0(DONE0), .DONE1(DONE1),
    .RESULT(RESULT), .ERR(ERR), .BUSY(BUSY),
    .M_LOADB(M_LOADB), .M_LOADQ(M_LOADQ), .M_G(M_G), .M_IN(M_IN),
    .M_OUT(s_out), .M_FINISH(s_fin)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Multiplier stub: FINISH idles high, drops after G, rises stub_lat cycles later.
  logic [N-1:0] s_a, s_b;
  int           s_cnt;
  int           stub_lat;
  bit           stub_hang;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s_fin <= 1'b1;
      s_cnt <= 0;
      s_out <= '0;
      s_a   <= '0;
      s_b   <= '0;
    end else begin
      if (M_LOADB) s_a <= M_IN;
      if (M_LOADQ) s_b <= M_IN;
      if (M_G) begin
        s_fin <= 1'b0;
        s_cnt <= stub_lat;
      end else if (!s_fin && !stub_hang) begin
        if (s_cnt == 0) begin
          s_fin <= 1'b1;
          s_out <= W'(s_a) * W'(s_b);
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end
    end
  end

  // Reference model: who wins, and what the product is.
  logic m_last;

  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) return m_last ? 0 : 1;
    if (r0)       return 0;
    return 1;
  endfunction

  function automatic logic [W-1:0] prod(input int a, input int b);
    return W'(a * b);
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic wait_ack(output int id, output int cyc);
    id  = -1;
    cyc = 0;
    while (id < 0 && cyc < 12) begin
      tick();
      cyc++;
      if (ACK0)      id = 0;
      else if (ACK1) id = 1;
    end
  endtask

  task automatic wait_done(input int start, output int id, output int cyc,
                           output logic [W-1:0] res, output logic err);
    id  = -1;
    cyc = start;
    res = 'x;
    err = 1'bx;
    while (id < 0 && cyc < start + TO + 20) begin
      tick();
      cyc++;
      if (DONE0 || DONE1) begin
        id  = DONE0 ? 0 : 1;
        res = RESULT;
        err = ERR;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    REQ0  = 1'b1;
    tick();
    n_tests++;
    if ({ACK0, ACK1, DONE0, DONE1, ERR, BUSY, M_LOADB, M_LOADQ, M_G} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000000",
               {ACK0, ACK1, DONE0, DONE1, ERR, BUSY, M_LOADB, M_LOADQ, M_G});
    end
    n_tests++;
    if (RESULT !== '0 || M_IN !== '0) begin
      n_fail++;
      $display("FAIL reset_data: RESULT=%h M_IN=%h want 0", RESULT, M_IN);
    end
    REQ0  = 1'b0;
    RESET = 1'b0;
    m_last = 1'b1;
    tick();
    n_tests++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: BUSY=%b want 0", BUSY);
    end
  endtask

  task automatic test_single();
    int id, cyc, c2;
    logic [W-1:0] res;
    logic err;
    do_reset();
    stub_lat = int'($urandom_range(0, 6));
    A0 = 4'd3; B0 = 4'd2; REQ0 = 1'b1;
    tick();
    n_tests++;
    if ({ACK0, ACK1, BUSY} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_ack: ACK0/ACK1/BUSY=%b want 101", {ACK0, ACK1, BUSY});
    end
    REQ0 = 1'b0;
    tick();
    n_tests++;
    if ({M_LOADB, M_LOADQ, M_G} !== 3'b100 || M_IN !== 4'd3) begin
      n_fail++;
      $display("FAIL single_loadb: strobes=%b M_IN=%0d want 100/3", {M_LOADB, M_LOADQ, M_G}, M_IN);
    end
    tick();
    n_tests++;
    if ({M_LOADB, M_LOADQ, M_G} !== 3'b010 || M_IN !== 4'd2) begin
      n_fail++;
      $display("FAIL single_loadq: strobes=%b M_IN=%0d want 010/2", {M_LOADB, M_LOADQ, M_G}, M_IN);
    end
    tick();
    n_tests++;
    if ({M_LOADB, M_LOADQ, M_G} !== 3'b001 || M_IN !== 4'd0) begin
      n_fail++;
      $display("FAIL single_start: strobes=%b M_IN=%0d want 001/0", {M_LOADB, M_LOADQ, M_G}, M_IN);
    end
    wait_done(4, id, c2, res, err);
    cyc = c2;
    n_tests++;
    if (id !== 0 || cyc !== 7 + stub_lat) begin
      n_fail++;
      $display("FAIL single_done: id=%0d cycle=%0d want id=0 cycle=%0d", id, cyc, 7 + stub_lat);
    end
    n_tests++;
    if (res !== 8'd6 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: RESULT=%0d ERR=%b want 6/0", res, err);
    end
    tick();
    n_tests++;
    if ({DONE0, DONE1, BUSY} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_after: DONE0/DONE1/BUSY=%b want 000", {DONE0, DONE1, BUSY});
    end
  endtask

  task automatic test_tie();
    int id, id2, cyc, cyc2, exp;
    logic [W-1:0] res;
    logic err;
    logic [N-1:0] a [2];
    logic [N-1:0] b [2];
    a[0] = 4'd5;  b[0] = 4'd7;
    a[1] = 4'd15; b[1] = 4'd15;
    do_reset();
    stub_lat = 2;
    for (int p = 0; p < 2; p++) begin
      A0 = a[0]; B0 = b[0]; A1 = a[1]; B1 = b[1];
      REQ0 = 1'b1; REQ1 = 1'b1;
      for (int k = 0; k < 2; k++) begin
        exp = pick(REQ0, REQ1);
        wait_ack(id, cyc);
        n_tests++;
        if (id !== exp) begin
          n_fail++;
          $display("FAIL tie_ack pass%0d op%0d: granted=%0d want %0d", p, k, id, exp);
        end
        m_last = exp[0];
        if (exp == 0) REQ0 = 1'b0;
        else          REQ1 = 1'b0;
        wait_done(cyc, id2, cyc2, res, err);
        n_tests++;
        if (id2 !== exp || res !== prod(int'(a[exp]), int'(b[exp])) || err !== 1'b0) begin
          n_fail++;
          $display("FAIL tie_done pass%0d op%0d: id=%0d RESULT=%0d ERR=%b want %0d/%0d/0",
                   p, k, id2, res, err, exp, prod(int'(a[exp]), int'(b[exp])));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int id, id2, cyc, cyc2, exp;
    logic [W-1:0] res;
    logic err;
    logic [W-1:0] want;
    do_reset();
    A0 = N'($urandom_range(0, 15)); B0 = N'($urandom_range(0, 15));
    A1 = N'($urandom_range(0, 15)); B1 = N'($urandom_range(0, 15));
    REQ0 = 1'b1; REQ1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      stub_lat = int'($urandom_range(0, 5));
      exp = pick(REQ0, REQ1);
      wait_ack(id, cyc);
      n_tests++;
      if (id !== exp) begin
        n_fail++;
        $display("FAIL rr_ack op%0d: granted=%0d want %0d", k, id, exp);
      end
      m_last = exp[0];
      want = (exp == 0) ? prod(int'(A0), int'(B0)) : prod(int'(A1), int'(B1));
      wait_done(cyc, id2, cyc2, res, err);
      n_tests++;
      if (id2 !== exp || res !== want || err !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_done op%0d: id=%0d RESULT=%0d ERR=%b want %0d/%0d/0", k, id2, res, err, exp, want);
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
  endtask

  task automatic test_operands();
    int id, id2, cyc, cyc2, r, a, b;
    logic [W-1:0] res;
    logic err;
    int tbl [4][3] = '{'{0, 0, 9}, '{1, 15, 15}, '{0, 15, 15}, '{1, 0, 0}};
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        r = tbl[k][0]; a = tbl[k][1]; b = tbl[k][2];
      end else begin
        r = int'($urandom_range(0, 1));
        a = int'($urandom_range(0, 15));
        b = int'($urandom_range(0, 15));
      end
      stub_lat = int'($urandom_range(0, 6));
      if (r == 0) begin A0 = N'(a); B0 = N'(b); REQ0 = 1'b1; end
      else        begin A1 = N'(a); B1 = N'(b); REQ1 = 1'b1; end
      wait_ack(id, cyc);
      n_tests++;
      if (id !== r) begin
        n_fail++;
        $display("FAIL ops_ack %0d: granted=%0d want %0d", k, id, r);
      end
      m_last = r[0];
      REQ0 = 1'b0; REQ1 = 1'b0;
      wait_done(cyc, id2, cyc2, res, err);
      n_tests++;
      if (id2 !== r || res !== prod(a, b) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL ops_done %0d (%0dx%0d): id=%0d RESULT=%0d ERR=%b want %0d/%0d/0",
                 k, a, b, id2, res, err, r, prod(a, b));
      end
    end
  endtask

  task automatic test_timeout();
    int id, id2, cyc, cyc2;
    logic [W-1:0] res;
    logic err;
    tick();
    stub_hang = 1'b1;
    stub_lat  = 1;
    A0 = 4'd11; B0 = 4'd13; REQ0 = 1'b1;
    wait_ack(id, cyc);
    REQ0 = 1'b0;
    wait_done(cyc, id2, cyc2, res, err);
    n_tests++;
    if (id2 !== 0 || cyc2 !== TO + 5) begin
      n_fail++;
      $display("FAIL timeout_done: id=%0d cycle=%0d want id=0 cycle=%0d", id2, cyc2, TO + 5);
    end
    n_tests++;
    if (res !== '0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: RESULT=%0d ERR=%b want 0/1", res, err);
    end
    stub_hang = 1'b0;
    stub_lat  = 3;
    A1 = 4'd9; B1 = 4'd6; REQ1 = 1'b1;
    wait_ack(id, cyc);
    REQ1 = 1'b0;
    wait_done(cyc, id2, cyc2, res, err);
    n_tests++;
    if (id2 !== 1 || res !== 8'd54 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_recover: id=%0d RESULT=%0d ERR=%b want 1/54/0", id2, res, err);
    end
  endtask

  task automatic test_reset_mid();
    int id, id2, cyc, cyc2, seen;
    logic [W-1:0] res;
    logic err;
    tick();
    stub_lat = 5;
    A1 = 4'd7; B1 = 4'd12; REQ1 = 1'b1;
    wait_ack(id, cyc);
    while (cyc < 8) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy: BUSY=%b want 1", BUSY);
    end
    RESET = 1'b1;
    #1;
    n_tests++;
    if ({ACK0, ACK1, DONE0, DONE1, ERR, BUSY, M_LOADB, M_LOADQ, M_G} !== 9'b0 ||
        RESULT !== '0 || M_IN !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: ctrl=%b RESULT=%0d M_IN=%0d want all 0",
               {ACK0, ACK1, DONE0, DONE1, ERR, BUSY, M_LOADB, M_LOADQ, M_G}, RESULT, M_IN);
    end
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (DONE0 || DONE1) seen++;
    end
    RESET  = 1'b0;
    m_last = 1'b1;
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midrst_nodone: DONE seen %0d times want 0", seen);
    end
    wait_ack(id, cyc);
    n_tests++;
    if (id !== 1 || cyc !== 1) begin
      n_fail++;
      $display("FAIL midrst_regrant: granted=%0d cycle=%0d want 1/1", id, cyc);
    end
    REQ1 = 1'b0;
    wait_done(cyc, id2, cyc2, res, err);
    n_tests++;
    if (id2 !== 1 || res !== 8'd84 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_result: id=%0d RESULT=%0d ERR=%b want 1/84/0", id2, res, err);
    end
  endtask

  initial begin
    RESET = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    stub_lat = 0;
    stub_hang = 1'b0;
    m_last = 1'b1;
    test_reset();
    test_single();
    test_tie();
    test_round_robin();
    test_operands();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 300000");
    $fatal(1, "bench time limit expired");
  end

endmodule
